// File: rtl/lisa_inst_emitter.sv
// Serialises one LISA instruction per accept into a byte stream:
// byte 0 = opcode, byte 1 = total length, then operand bytes.
module lisa_inst_emitter #(
    parameter int MAX_BYTES = 16
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [7:0]             in_opcode,
    input  logic [7:0]             in_len,
    input  logic [MAX_BYTES*8-1:0] in_bytes,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [7:0]             out_byte,
    output logic                   out_first,
    output logic                   out_last,
    output logic                   err_len,
    output logic [15:0]            inst_count,
    output logic                   busy
);
    // state | meaning
    // IDLE  | waiting for an instruction; in_ready high
    // SEND  | streaming buffer[idx] until the byte at len-1 transfers
    localparam int         IW      = (MAX_BYTES > 1) ? $clog2(MAX_BYTES) : 1;
    localparam logic [7:0] MAX_LEN = 8'(MAX_BYTES);
    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_SEND  = 1'b1;

    logic [0:0]    state_q, state_d;
    logic [7:0]    buf_q [MAX_BYTES];
    logic [7:0]    buf_d [MAX_BYTES];
    logic [7:0]    len_q, len_d;
    logic [IW-1:0] idx_q, idx_d;
    logic          err_q, err_d;
    logic [15:0]   inst_count_q, inst_count_d;
    logic          sending;
    logic          is_last;
    logic          len_ok;

    assign sending = (state_q == S_SEND);
    assign is_last = (8'(idx_q) == (len_q - 8'd1));
    assign len_ok  = (in_len >= 8'd2) && (in_len <= MAX_LEN);

    always_comb begin
        state_d      = state_q;
        buf_d        = buf_q;
        len_d        = len_q;
        idx_d        = idx_q;
        err_d        = 1'b0;
        inst_count_d = inst_count_q;
        case (state_q)
            S_IDLE: begin
                if (in_valid) begin
                    if (len_ok) begin
                        // image bytes 0/1 are replaced by opcode and length
                        for (int k = 0; k < MAX_BYTES; k++) begin
                            buf_d[k] = in_bytes[k*8 +: 8];
                        end
                        buf_d[0] = in_opcode;
                        buf_d[1] = in_len;
                        len_d    = in_len;
                        idx_d    = '0;
                        state_d  = S_SEND;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            default: begin
                if (out_ready) begin
                    if (is_last) begin
                        inst_count_d = inst_count_q + 16'd1;
                        state_d      = S_IDLE;
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= S_IDLE;
            len_q        <= '0;
            idx_q        <= '0;
            err_q        <= 1'b0;
            inst_count_q <= '0;
        end else begin
            state_q      <= state_d;
            len_q        <= len_d;
            idx_q        <= idx_d;
            err_q        <= err_d;
            inst_count_q <= inst_count_d;
        end
    end

    // Buffer contents are only observed in SEND, so it needs no reset.
    always_ff @(posedge clk) begin
        buf_q <= buf_d;
    end

    assign in_ready   = ~rst & ~sending;
    assign out_valid  = sending;
    assign busy       = sending;
    assign out_byte   = sending ? buf_q[idx_q] : 8'h00;
    assign out_first  = sending && (idx_q == '0);
    assign out_last   = sending && is_last;
    assign err_len    = err_q;
    assign inst_count = inst_count_q;

endmodule

// File: tb/tb_lisa_inst_emitter.sv
// Directed bench for lisa_inst_emitter with hand-derived expected byte streams.
module tb_lisa_inst_emitter;
    localparam int MB = 16;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid;
    logic          in_ready;
    logic [7:0]    in_opcode;
    logic [7:0]    in_len;
    logic [MB*8-1:0] in_bytes;
    logic          out_valid;
    logic          out_ready;
    logic [7:0]    out_byte;
    logic          out_first;
    logic          out_last;
    logic          err_len;
    logic [15:0]   inst_count;
    logic          busy;

    int            total = 0;
    int            bad = 0;
    logic [15:0]   exp_cnt = 16'd0;
    logic [7:0]    exp_b [MB];

    lisa_inst_emitter #(.MAX_BYTES(MB)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_opcode(in_opcode), .in_len(in_len), .in_bytes(in_bytes),
        .out_valid(out_valid), .out_ready(out_ready), .out_byte(out_byte),
        .out_first(out_first), .out_last(out_last),
        .err_len(err_len), .inst_count(inst_count), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Operand byte k of opcode opc is opc ^ (0x40 + k); bytes 0/1 of the image are junk.
    task automatic present(input logic [7:0] opc, input logic [7:0] len);
        in_opcode = opc;
        in_len    = len;
        in_bytes  = '1;
        for (int k = 2; k < MB; k++) begin
            in_bytes[k*8 +: 8] = opc ^ 8'(8'h40 + k);
            exp_b[k]           = opc ^ 8'(8'h40 + k);
        end
        exp_b[0] = opc;
        exp_b[1] = len;
    endtask

    task automatic accept();
        chk("acc_ready", in_ready, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        in_opcode = 8'hEE;
        in_len    = 8'h07;
        in_bytes  = '0;
        chk("acc_busy", busy, 1);
    endtask

    // mode 0: out_ready always 1; mode 1: out_ready pattern 1,0,0,1 repeating
    task automatic collect(input int len, input int mode);
        int   n;
        int   cyc;
        logic r;
        n   = 0;
        cyc = 0;
        while (n < len && cyc < 400) begin
            r = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
            out_ready = r;
            chk("s_valid", out_valid, 1);
            chk("s_byte", out_byte, exp_b[n]);
            chk("s_first", out_first, (n == 0));
            chk("s_last", out_last, (n == len - 1));
            if (r) n++;
            cyc++;
            tick();
        end
        chk("xfers", n, len);
        exp_cnt = exp_cnt + 16'd1;
        chk("done_valid", out_valid, 0);
        chk("done_ready", in_ready, 1);
        chk("done_count", inst_count, exp_cnt);
        out_ready = 1'b1;
    endtask

    task automatic illegal(input logic [7:0] len);
        present(8'h77, len);
        chk("ill_ready", in_ready, 1);
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        chk("ill_err", err_len, 1);
        chk("ill_valid", out_valid, 0);
        tick();
        chk("ill_err_clr", err_len, 0);
        chk("ill_valid2", out_valid, 0);
        chk("ill_count", inst_count, exp_cnt);
    endtask

    initial begin
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
        in_opcode = '0; in_len = '0; in_bytes = '0;
        tick();
        tick();
        chk("rst_valid", out_valid, 0);
        chk("rst_ready", in_ready, 0);
        chk("rst_busy", busy, 0);
        chk("rst_err", err_len, 0);
        chk("rst_count", inst_count, 0);
        chk("rst_byte", out_byte, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        rst = 1'b0;
        #1;
        chk("rel_ready", in_ready, 1);

        // basic 4-byte instruction
        present(8'h12, 8'd4);
        in_bytes[23:16] = 8'hAA; exp_b[2] = 8'hAA;
        in_bytes[31:24] = 8'hBB; exp_b[3] = 8'hBB;
        out_ready = 1'b1;
        accept();
        collect(4, 0);

        // same instruction under stalls
        present(8'h12, 8'd4);
        in_bytes[23:16] = 8'hAA; exp_b[2] = 8'hAA;
        in_bytes[31:24] = 8'hBB; exp_b[3] = 8'hBB;
        accept();
        collect(4, 1);

        // length rejects and maximum length
        illegal(8'd1);
        illegal(8'd17);
        illegal(8'd0);
        present(8'hC3, 8'd16);
        accept();
        collect(16, 0);

        // three len=2 instructions with in_valid held high
        out_ready = 1'b1;
        for (int i = 0; i < 3; i++) begin
            present(8'(8'h50 + i), 8'd2);
            in_valid = 1'b1;
            chk("b2b_ready", in_ready, 1);
            tick();
            chk("b2b_first", out_first, 1);
            chk("b2b_b0", out_byte, 8'(8'h50 + i));
            tick();
            chk("b2b_last", out_last, 1);
            chk("b2b_b1", out_byte, 8'd2);
            tick();
        end
        in_valid = 1'b0;
        exp_cnt = exp_cnt + 16'd3;
        chk("b2b_count", inst_count, exp_cnt);
        chk("b2b_idle", out_valid, 0);

        // reset in the middle of a 6-byte instruction
        present(8'h9D, 8'd6);
        accept();
        for (int n = 0; n < 3; n++) begin
            chk("mid_byte", out_byte, exp_b[n]);
            tick();
        end
        chk("mid_b3", out_byte, exp_b[3]);
        rst = 1'b1;
        tick();
        chk("mid_valid", out_valid, 0);
        chk("mid_count", inst_count, 0);
        chk("mid_busy", busy, 0);
        chk("mid_ready", in_ready, 0);
        rst = 1'b0;
        exp_cnt = 16'd0;
        #1;
        present(8'h3C, 8'd5);
        accept();
        collect(5, 0);

        // counter wrap
        force dut.inst_count_q = 16'hFFFF;
        #1;
        release dut.inst_count_q;
        #1;
        exp_cnt = 16'hFFFF;
        chk("wrap_pre", inst_count, 16'hFFFF);
        present(8'hA5, 8'd3);
        accept();
        collect(3, 0);
        chk("wrap_zero", inst_count, 16'h0000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lisa_inst_emitter.md
Name: lisa_inst_emitter

Overview:
Serialises one LISA instruction per handshake into a byte stream. The stream uses the same format the fetch side consumes: byte 0 = opcode, byte 1 = total length in bytes, then operand bytes. The block sits on the write/producer side, e.g. a loader or trace replayer filling instruction memory. It rejects lengths that the fetch side would flag invalid.

Parameters:
MAX_BYTES, 16, maximum instruction length in bytes (legal range 2..255); also the width in bytes of in_bytes.

Ports:
clk  input  1  clock; all state updates on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  instruction presented
in_ready  output  1  emitter can accept an instruction
in_opcode  input  8  opcode, emitted as byte 0
in_len  input  8  total instruction length, emitted as byte 1
in_bytes  input  MAX_BYTES*8  instruction image; byte k = in_bytes[k*8+:8]; bytes 0 and 1 ignored
out_valid  output  1  out_byte is valid
out_ready  input  1  downstream accepts out_byte
out_byte  output  8  current stream byte
out_first  output  1  out_byte is byte 0 (opcode) of an instruction
out_last  output  1  out_byte is the final byte of an instruction
err_len  output  1  one-cycle pulse: an instruction was rejected for illegal length
inst_count  output  16  count of fully emitted instructions; wraps 0xFFFF->0
busy  output  1  high while in SEND

Behaviour:
- Reset (rst=1 at clock edge):
  - state=IDLE; out_valid=0, err_len=0, inst_count=0, busy=0, out_first=0, out_last=0; out_byte=0.
  - Any partially emitted instruction is abandoned and never resumed.
  - in_ready is 0 while rst is high.
- States: IDLE, SEND.
- IDLE:
  - in_ready=1, out_valid=0.
  - Accept occurs when in_valid=1 at the clock edge.
  - Legal length means 2 <= in_len <= MAX_BYTES. On a legal accept:
    - Latch buffer: byte0=in_opcode, byte1=in_len, bytes 2..MAX_BYTES-1 from in_bytes.
    - Latch len; set idx=0; go to SEND.
  - Illegal length: drop the instruction, assert err_len for exactly the next cycle, remain in IDLE, leave inst_count unchanged.
- SEND:
  - in_ready=0, out_valid=1, busy=1.
  - out_byte=buffer[idx]; out_first=(idx==0); out_last=(idx==len-1).
  - All outputs are registered or derived from registered state only; no combinational path from out_ready to out_valid or out_byte.
  - Transfer occurs when out_valid and out_ready are both high at the edge. On transfer:
    - If not last: idx++.
    - If last: inst_count++ (modulo 2^16) and go to IDLE.
  - out_ready=0 stalls: out_byte, out_first, out_last and idx are held unchanged, and out_valid stays 1 (no retraction).
- Throughput: an instruction of length L occupies 1 accept cycle plus L transfer cycles. Minimum 1 idle cycle between instructions; no same-cycle accept on the last transfer.
- len=2: out_first on byte 0, out_last on byte 1; operand bytes unused.
- len=MAX_BYTES: idx reaches MAX_BYTES-1 with no overflow. idx width = clog2(MAX_BYTES).
- in_* inputs are ignored outside the accept edge; changes during SEND have no effect.
- err_len and a legal accept can never occur in the same cycle.

Test Plan:
- Reset, then in_opcode=0x12, in_len=4, in_bytes bytes2/3=0xAA/0xBB, out_ready=1 -> stream 0x12,0x04,0xAA,0xBB on 4 consecutive cycles starting the cycle after accept. out_first on 0x12, out_last on 0xBB, inst_count=1, in_ready back to 1.
- Same instruction with out_ready toggling 1,0,0,1,... -> bytes held stable with out_valid=1 during stalls; sequence unchanged; exactly 4 transfers.
- in_len=1, then in_len=17 (MAX_BYTES=16) -> each gives a one-cycle err_len pulse, no out_valid, inst_count unchanged. in_len=16 -> 16 bytes emitted, out_last on byte 15.
- in_len=2 back-to-back ×3 with in_valid held high -> 2 bytes per instruction, one in_ready cycle between instructions, inst_count=3.
- rst asserted after byte 2 of a 6-byte instruction -> next cycle out_valid=0, inst_count=0, state IDLE. A new instruction then emits cleanly from byte 0.
- Preload 65535 completed instructions (or force the counter), emit one more -> inst_count wraps to 0.
